// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// States, forwarding select codes and per-source hit helpers.
package cpu_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef struct packed {
    logic ex;
    logic mem;
    logic wb;
  } hit_t;

  // Nearest producer wins.
  function automatic logic [1:0] fwd_sel(hit_t h);
    if (h.ex)       return FWD_EXMEM;
    else if (h.mem) return FWD_WB;
    else            return FWD_REGFILE;
  endfunction

  function automatic logic [1:0] raw_wait(hit_t h);
    if (h.ex)       return 2'd3;
    else if (h.mem) return 2'd2;
    else if (h.wb)  return 2'd1;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Matches one ID source register against the EX/MEM/WB writers.
// x0 and unused sources never produce a hit.
module hazard_cmp
  import cpu_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic          use_src,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_wr,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_wr,
  output hit_t          hit
);

  logic live;

  assign live = use_src && (src != '0);

  always_comb begin
    hit     = '0;
    hit.ex  = live && ex_wr && (ex_rd == src);
    hit.mem = live && mem_wr && (mem_rd == src);
    hit.wb  = live && wb_wr && (wb_rd == src);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage core; all outputs registered.
// Define FORWARDING_EN for bypassing with a load-use bubble; else RAW stalls.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = cpu_ctrl_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  mem_redirect,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  import cpu_ctrl_pkg::*;

  ctrl_state_e st;
  logic [1:0]  stall_rem;
  hit_t        h1;
  hit_t        h2;
  logic [1:0]  wait_n;
  logic [1:0]  fa;
  logic [1:0]  fb;

  hazard_cmp #(.AW(REG_ADDR_W)) u_rs1 (
    .src     (id_rs1),
    .use_src (id_use_rs1),
    .ex_rd   (ex_rd),
    .ex_wr   (ex_reg_write),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_reg_write),
    .wb_rd   (wb_rd),
    .wb_wr   (wb_reg_write),
    .hit     (h1)
  );

  hazard_cmp #(.AW(REG_ADDR_W)) u_rs2 (
    .src     (id_rs2),
    .use_src (id_use_rs2),
    .ex_rd   (ex_rd),
    .ex_wr   (ex_reg_write),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_reg_write),
    .wb_rd   (wb_rd),
    .wb_wr   (wb_reg_write),
    .hit     (h2)
  );

`ifdef FORWARDING_EN
  logic unused_wb;
  assign unused_wb = h1.wb ^ h2.wb;

  always_comb begin
    wait_n = 2'd0;
    if (ex_mem_read && (h1.ex || h2.ex))
      wait_n = 2'd1;
    fa = fwd_sel(h1);
    fb = fwd_sel(h2);
  end
`else
  logic unused_ld;
  assign unused_ld = ex_mem_read;

  // Worst of the two sources sets the stall length.
  always_comb begin
    wait_n = raw_wait(h1);
    if (raw_wait(h2) > wait_n)
      wait_n = raw_wait(h2);
    fa = FWD_REGFILE;
    fb = FWD_REGFILE;
  end
`endif

  assign state = st;

  always_ff @(posedge clk) begin
    if (srst) begin
      st           <= ST_IDLE;
      stall_rem    <= 2'd0;
      pc_en        <= 1'b0;
      if_id_en     <= 1'b0;
      if_id_flush  <= 1'b0;
      id_ex_flush  <= 1'b0;
      ex_mem_flush <= 1'b0;
      fwd_a_sel    <= FWD_REGFILE;
      fwd_b_sel    <= FWD_REGFILE;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      pc_en        <= 1'b0;
      if_id_en     <= 1'b0;
      if_id_flush  <= 1'b0;
      id_ex_flush  <= 1'b0;
      ex_mem_flush <= 1'b0;
      fwd_a_sel    <= FWD_REGFILE;
      fwd_b_sel    <= FWD_REGFILE;
      if (!enable) begin
        st        <= ST_IDLE;
        stall_rem <= 2'd0;
      end else if (st == ST_IDLE) begin
        st       <= ST_RUN;
        pc_en    <= 1'b1;
        if_id_en <= 1'b1;
      end else if (mem_redirect) begin
        st           <= ST_FLUSH;
        stall_rem    <= 2'd0;
        pc_en        <= 1'b1;
        if_id_en     <= 1'b1;
        if_id_flush  <= 1'b1;
        id_ex_flush  <= 1'b1;
        ex_mem_flush <= 1'b1;
        flush_cnt    <= flush_cnt + CNT_W'(1);
      end else if (st == ST_FLUSH) begin
        st       <= ST_RUN;
        pc_en    <= 1'b1;
        if_id_en <= 1'b1;
      end else if (st == ST_STALL && stall_rem != 2'd0) begin
        stall_rem   <= stall_rem - 2'd1;
        id_ex_flush <= 1'b1;
        stall_cnt   <= stall_cnt + CNT_W'(1);
      end else if (wait_n != 2'd0) begin
        st          <= ST_STALL;
        stall_rem   <= wait_n - 2'd1;
        id_ex_flush <= 1'b1;
        stall_cnt   <= stall_cnt + CNT_W'(1);
      end else begin
        st        <= ST_RUN;
        pc_en     <= 1'b1;
        if_id_en  <= 1'b1;
        fwd_a_sel <= fa;
        fwd_b_sel <= fb;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (directed + random vs model).
// Honours FORWARDING_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_STALL = 2;
  localparam int S_FLUSH = 3;

  logic        clk = 1'b0;
  logic        srst, enable;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic        mem_redirect;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel, state;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_st;
  int          m_rem;
  logic [31:0] m_stall, m_flush;
  bit          m_pc, m_ifl, m_idl, m_exl;
  int          m_fa, m_fb;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .srst(srst), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_redirect(mem_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Distance to nearest writer of r: 1=EX, 2=MEM, 3=WB, 0=none.
  function automatic int nearest(logic [4:0] r, logic u);
    if (!u || r == 5'd0) return 0;
    if (ex_reg_write && ex_rd == r) return 1;
    if (mem_reg_write && mem_rd == r) return 2;
    if (wb_reg_write && wb_rd == r) return 3;
    return 0;
  endfunction

  function automatic int bubbles(int d);
`ifdef FORWARDING_EN
    return (d == 1 && ex_mem_read) ? 1 : 0;
`else
    return (d == 0) ? 0 : 4 - d;
`endif
  endfunction

  function automatic int fwd_of(int d);
`ifdef FORWARDING_EN
    return (d == 1) ? 2 : (d == 2) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    int d1, d2, need;
    d1 = nearest(id_rs1, id_use_rs1);
    d2 = nearest(id_rs2, id_use_rs2);
    need = bubbles(d1) > bubbles(d2) ? bubbles(d1) : bubbles(d2);
    m_pc = 0; m_ifl = 0; m_idl = 0; m_exl = 0; m_fa = 0; m_fb = 0;
    if (srst) begin
      m_st = S_IDLE; m_rem = 0; m_stall = 0; m_flush = 0;
    end else if (!enable) begin
      m_st = S_IDLE; m_rem = 0;
    end else if (m_st == S_IDLE) begin
      m_st = S_RUN; m_pc = 1;
    end else if (mem_redirect) begin
      m_st = S_FLUSH; m_rem = 0; m_pc = 1;
      m_ifl = 1; m_idl = 1; m_exl = 1;
      m_flush = m_flush + 1;
    end else if (m_st == S_FLUSH) begin
      m_st = S_RUN; m_pc = 1;
    end else if (m_st == S_STALL && m_rem > 0) begin
      m_rem = m_rem - 1; m_idl = 1; m_stall = m_stall + 1;
    end else if (need > 0) begin
      m_st = S_STALL; m_rem = need - 1; m_idl = 1;
      m_stall = m_stall + 1;
    end else begin
      m_st = S_RUN; m_pc = 1;
      m_fa = fwd_of(d1); m_fb = fwd_of(d2);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    mem_redirect = 0;
  endtask

  task automatic load_hazard();
    quiet();
    ex_rd = 5'd6; ex_reg_write = 1; ex_mem_read = 1;
    id_rs2 = 5'd6; id_use_rs2 = 1;
  endtask

  task automatic test_reset();
    quiet();
    enable = 1; srst = 1;
    tick(); tick();
    checks++;
    if (state !== 2'd0 || pc_en !== 1'b0 || if_id_en !== 1'b0 ||
        id_ex_flush !== 1'b0 || fwd_a_sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: state=%0d pc_en=%b if_id_en=%b want 0/0/0",
               state, pc_en, if_id_en);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: stall=%0d flush=%0d want 0/0",
               stall_cnt, flush_cnt);
    end
    srst = 0;
    tick();
    checks++;
    if (state !== 2'd1 || pc_en !== 1'b1 || if_id_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_run: state=%0d pc_en=%b want 1/1",
               state, pc_en);
    end
  endtask

`ifdef FORWARDING_EN
  task automatic test_fwd_ex();
    quiet();
    ex_rd = 5'd5; ex_reg_write = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
    tick();
    checks++;
    if (fwd_a_sel !== 2'b10 || pc_en !== 1'b1 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL fwd_ex: fwd_a=%0d pc_en=%b stall=%0d want 2/1/0",
               fwd_a_sel, pc_en, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    load_hazard();
    tick();
    checks++;
    if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_flush !== 1'b1 ||
        state !== 2'd2 || stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL load_use_bubble: pc_en=%b idex_fl=%b st=%0d stall=%0d want 0/1/2/1",
               pc_en, id_ex_flush, state, stall_cnt);
    end
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_rd = 5'd6; mem_reg_write = 1;
    tick();
    checks++;
    if (fwd_b_sel !== 2'b01 || pc_en !== 1'b1 || state !== 2'd1 ||
        id_ex_flush !== 1'b0 || stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL load_use_resume: fwd_b=%0d pc_en=%b st=%0d stall=%0d want 1/1/1/1",
               fwd_b_sel, pc_en, state, stall_cnt);
    end
  endtask
`else
  task automatic test_raw_stall();
    quiet();
    ex_rd = 5'd7; ex_reg_write = 1; id_rs1 = 5'd7; id_use_rs1 = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pc_en !== 1'b0 || id_ex_flush !== 1'b1 || state !== 2'd2 ||
          stall_cnt !== 32'(i)) begin
        failures++;
        $display("FAIL raw_stall_cycle%0d: pc_en=%b idex_fl=%b st=%0d stall=%0d want 0/1/2/%0d",
                 i, pc_en, id_ex_flush, state, stall_cnt, i);
      end
      ex_reg_write = 0;
      mem_rd = (i == 1) ? 5'd7 : 5'd0; mem_reg_write = (i == 1);
      wb_rd = (i == 2) ? 5'd7 : 5'd0; wb_reg_write = (i == 2);
    end
    tick();
    checks++;
    if (pc_en !== 1'b1 || state !== 2'd1 || stall_cnt !== 32'd3 ||
        fwd_a_sel !== 2'd0) begin
      failures++;
      $display("FAIL raw_stall_release: pc_en=%b st=%0d stall=%0d fwd=%0d want 1/1/3/0",
               pc_en, state, stall_cnt, fwd_a_sel);
    end
  endtask
`endif

  task automatic test_x0();
    quiet();
    ex_rd = 5'd0; ex_reg_write = 1; ex_mem_read = 1;
    mem_rd = 5'd0; mem_reg_write = 1;
    id_rs1 = 5'd0; id_use_rs1 = 1;
    tick();
    checks++;
    if (pc_en !== 1'b1 || state !== 2'd1 || fwd_a_sel !== 2'd0 ||
        id_ex_flush !== 1'b0) begin
      failures++;
      $display("FAIL x0_no_hazard: pc_en=%b st=%0d fwd_a=%0d want 1/1/0",
               pc_en, state, fwd_a_sel);
    end
  endtask

  task automatic test_redirect_in_stall();
    load_hazard();
    tick();
    checks++;
    if (state !== 2'd2 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL redirect_pre_stall: st=%0d pc_en=%b want 2/0", state, pc_en);
    end
    mem_redirect = 1;
    tick();
    checks++;
    if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || ex_mem_flush !== 1'b1 ||
        pc_en !== 1'b1 || state !== 2'd3 || flush_cnt !== 32'd1 ||
        stall_cnt !== m_stall) begin
      failures++;
      $display("FAIL redirect_flush: fl=%b%b%b pc_en=%b st=%0d fcnt=%0d scnt=%0d want 111/1/3/1/%0d",
               if_id_flush, id_ex_flush, ex_mem_flush, pc_en, state,
               flush_cnt, stall_cnt, m_stall);
    end
    quiet();
    tick();
    checks++;
    if (state !== 2'd1 || pc_en !== 1'b1 || if_id_flush !== 1'b0 ||
        ex_mem_flush !== 1'b0 || flush_cnt !== 32'd1) begin
      failures++;
      $display("FAIL redirect_resume: st=%0d pc_en=%b fl=%b%b fcnt=%0d want 1/1/00/1",
               state, pc_en, if_id_flush, ex_mem_flush, flush_cnt);
    end
  endtask

  task automatic test_disable_mid_stall();
    logic [31:0] held;
    load_hazard();
    tick();
    held = m_stall;
    enable = 0;
    tick(); tick();
    checks++;
    if (state !== 2'd0 || pc_en !== 1'b0 || id_ex_flush !== 1'b0 ||
        stall_cnt !== held || flush_cnt !== 32'd1) begin
      failures++;
      $display("FAIL disable_mid_stall: st=%0d pc_en=%b idex=%b scnt=%0d want 0/0/0/%0d",
               state, pc_en, id_ex_flush, stall_cnt, held);
    end
    quiet();
    enable = 1;
    tick();
    checks++;
    if (state !== 2'd1 || pc_en !== 1'b1) begin
      failures++;
      $display("FAIL reenable_run: st=%0d pc_en=%b want 1/1", state, pc_en);
    end
  endtask

  task automatic test_srst_mid_stall();
    load_hazard();
    tick();
    srst = 1;
    tick();
    checks++;
    if (state !== 2'd0 || pc_en !== 1'b0 || id_ex_flush !== 1'b0 ||
        stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++;
      $display("FAIL srst_mid_stall: st=%0d pc_en=%b scnt=%0d fcnt=%0d want 0/0/0/0",
               state, pc_en, stall_cnt, flush_cnt);
    end
    srst = 0;
    quiet();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      srst = ($urandom_range(0, 99) < 2);
      enable = ($urandom_range(0, 99) < 95);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = ($urandom_range(0, 9) < 7);
      id_use_rs2 = ($urandom_range(0, 9) < 7);
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      ex_reg_write = $urandom_range(0, 1) == 1;
      ex_mem_read = ($urandom_range(0, 9) < 3);
      mem_reg_write = $urandom_range(0, 1) == 1;
      wb_reg_write = $urandom_range(0, 1) == 1;
      mem_redirect = ($urandom_range(0, 99) < 8);
      tick();
      checks++;
      if (state !== 2'(m_st) || pc_en !== m_pc || if_id_en !== m_pc ||
          if_id_flush !== m_ifl || id_ex_flush !== m_idl ||
          ex_mem_flush !== m_exl || fwd_a_sel !== 2'(m_fa) ||
          fwd_b_sel !== 2'(m_fb) || stall_cnt !== m_stall ||
          flush_cnt !== m_flush) begin
        failures++;
        $display("FAIL random_cycle%0d: st=%0d pc=%b ifid=%b fl=%b%b%b fa=%0d fb=%0d sc=%0d fc=%0d want st=%0d pc=%b fl=%b%b%b fa=%0d fb=%0d sc=%0d fc=%0d",
                 i, state, pc_en, if_id_en, if_id_flush, id_ex_flush,
                 ex_mem_flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                 m_st, m_pc, m_ifl, m_idl, m_exl, m_fa, m_fb, m_stall, m_flush);
      end
    end
  endtask

  initial begin
    m_st = S_IDLE; m_rem = 0; m_stall = 0; m_flush = 0;
    m_pc = 0; m_ifl = 0; m_idl = 0; m_exl = 0; m_fa = 0; m_fb = 0;
    srst = 1; enable = 0;
    quiet();
    test_reset();
`ifdef FORWARDING_EN
    test_fwd_ex();
    test_load_use();
`else
    test_raw_stall();
`endif
    test_x0();
    test_redirect_in_stall();
    test_disable_mid_stall();
    test_srst_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
